// File: rtl/float_to_log_encoder.sv
// Float -> sign + M.F log2 magnitude, fraction bits by repeated squaring, one conversion in flight.
// Latency: F+2 cycles after accept on the normal path, 1 edge for zero/inf/saturating inputs.
// Backpressure: result held in DONE until out_ready; in_ready only while idle.
module float_to_log_encoder #(
    parameter int EXP  = 8,
    parameter int FRAC = 23,
    parameter int M    = 3,
    parameter int F    = 4,
    parameter int SQ_W = F + 8
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [EXP+FRAC:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [M+F:0]        out_data
);

    localparam int EW    = EXP + 2;
    localparam int VW    = M + F + 1;
    localparam int CNT_W = $clog2(F + 1);

    localparam logic signed [EW-1:0] BIAS_W = EW'(2 ** (EXP - 1) - 1);
    localparam logic signed [EW-1:0] E_MAX  = EW'(2 ** (M - 1));
    localparam logic signed [EW-1:0] E_MIN  = -E_MAX;
    localparam logic signed [VW-1:0] V_MAX  = VW'(2 ** (M + F - 1) - 1);
    localparam logic signed [VW-1:0] V_MIN  = -VW'(2 ** (M + F - 1));

    localparam logic [M+F-1:0] RSV_L = {1'b1, {(M + F - 1){1'b0}}};
    localparam logic [M+F-1:0] MAX_L = {1'b0, {(M + F - 1){1'b1}}};
    localparam logic [M+F:0]   ZERO_CODE = {1'b0, RSV_L};
    localparam logic [M+F:0]   INF_CODE  = {1'b1, RSV_L};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        ROUND,
        DONE
    } state_t;

    state_t                 state;
    logic                   sign_q;
    logic signed [M:0]      e_q;
    logic [SQ_W:0]          y_q;
    logic [F:0]             f_q;
    logic [CNT_W-1:0]       cnt_q;

    logic                   in_sign;
    logic [EXP-1:0]         in_exp;
    logic [FRAC-1:0]        in_frac;
    logic signed [EW-1:0]   in_e;
    logic [SQ_W-1:0]        frac_rs;

    assign in_sign = in_data[EXP+FRAC];
    assign in_exp  = in_data[EXP+FRAC-1:FRAC];
    assign in_frac = in_data[FRAC-1:0];
    assign in_e    = signed'({2'b00, in_exp}) - BIAS_W;

    // Mantissa resized to SQ_W fraction bits: drop low bits or zero-pad.
    if (FRAC >= SQ_W) begin : g_frac_trunc
        assign frac_rs = SQ_W'(in_frac >> (FRAC - SQ_W));
    end else begin : g_frac_pad
        assign frac_rs = SQ_W'(in_frac) << (SQ_W - FRAC);
    end

    logic [2*SQ_W+1:0]      sq_full;
    logic [SQ_W+1:0]        sq_trunc;
    logic                   sq_bit;
    logic [SQ_W:0]          y_next;

    // y in [1,2) so y*y in [1,4): the integer MSB is the next log fraction bit.
    assign sq_full  = {{(SQ_W + 1){1'b0}}, y_q} * {{(SQ_W + 1){1'b0}}, y_q};
    assign sq_trunc = (SQ_W + 2)'(sq_full >> SQ_W);
    assign sq_bit   = sq_trunc[SQ_W+1];
    assign y_next   = sq_bit ? sq_trunc[SQ_W+1:1] : sq_trunc[SQ_W:0];

    logic signed [VW-1:0]   v_base;
    logic signed [VW-1:0]   v_sum;

    assign v_base = {e_q, f_q[F:1]};
    assign v_sum  = v_base + {{(VW - 1){1'b0}}, f_q[0]};

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            sign_q    <= 1'b0;
            e_q       <= '0;
            y_q       <= '0;
            f_q       <= '0;
            cnt_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q <= in_sign;
                        e_q    <= in_e[M:0];
                        y_q    <= {1'b1, frac_rs};
                        f_q    <= '0;
                        cnt_q  <= '0;
                        in_ready <= 1'b0;
                        if (in_exp == '0) begin
                            out_data  <= ZERO_CODE;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else if (in_exp == '1) begin
                            out_data  <= INF_CODE;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else if (in_e >= E_MAX) begin
                            out_data  <= {in_sign, MAX_L};
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else if (in_e < E_MIN) begin
                            out_data  <= ZERO_CODE;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    y_q <= y_next;
                    f_q <= {f_q[F-1:0], sq_bit};
                    if (cnt_q == CNT_W'(F)) begin
                        state <= ROUND;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ROUND: begin
                    // Rounding carry can push past the largest finite code; clamp rather than emit inf.
                    if (v_sum > V_MAX) begin
                        out_data <= {sign_q, MAX_L};
                    end else if (v_sum <= V_MIN) begin
                        out_data <= ZERO_CODE;
                    end else begin
                        out_data <= {sign_q, v_sum[M+F-1:0]};
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_float_to_log_encoder.sv
// Directed and random float conversions against an arithmetic log2 reference model.
module tb_float_to_log_encoder;

    localparam int F = 4;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    float_to_log_encoder dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: log2 of 1.frac by squaring a 12-bit-fraction integer, then round and clamp.
    function automatic logic [7:0] ref_log(input logic [31:0] x, output int lat);
        int     ex;
        int     e;
        int     f;
        int     v;
        longint y;
        lat = 0;
        ex  = int'(x[30:23]);
        if (ex == 0)   return 8'h40;
        if (ex == 255) return 8'hC0;
        e = ex - 127;
        if (e >= 4)  return {x[31], 7'h3F};
        if (e < -4)  return 8'h40;
        y = 4096 + longint'(x[22:11]);
        f = 0;
        for (int i = 0; i < F + 1; i++) begin
            y = (y * y) / 4096;
            if (y >= 8192) begin
                f = 2 * f + 1;
                y = y / 2;
            end else begin
                f = 2 * f;
            end
        end
        v   = e * 16 + f / 2 + f % 2;
        lat = F + 2;
        if (v > 63)   return {x[31], 7'h3F};
        if (v <= -64) return 8'h40;
        return {x[31], 7'(v)};
    endfunction

    task automatic convert(input logic [31:0] din, input logic [7:0] exp_dat,
                           input int exp_lat, input int hold, input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        chk({tag, ":in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        in_data  = din;
        @(posedge clock); #1;
        // Keep offering garbage: it must be ignored until the next idle cycle.
        in_data = $urandom;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        chk({tag, ":latency"}, n, exp_lat);
        chk({tag, ":data"}, out_data, exp_dat);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            chk({tag, ":hold"}, {out_valid, in_ready, out_data}, {1'b1, 1'b0, exp_dat});
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk({tag, ":handoff"}, {out_valid, in_ready}, 2'b01);
        in_valid = 1'b0;
    endtask

    logic [31:0] dir_in  [16] = '{32'h3F800000, 32'h40000000, 32'hBF000000, 32'h3FB504F3,
                                  32'h00000000, 32'h00000001, 32'h7FC00000, 32'hFF800000,
                                  32'h44800000, 32'h417B3333, 32'h3A800000, 32'h80000000,
                                  32'h3D800000, 32'hC1000000, 32'h41800000, 32'hC1800000};
    logic [7:0]  dir_out [16] = '{8'h00, 8'h10, 8'hF0, 8'h08,
                                  8'h40, 8'h40, 8'hC0, 8'hC0,
                                  8'h3F, 8'h3F, 8'h40, 8'h40,
                                  8'h40, 8'hB0, 8'h3F, 8'hBF};
    int          dir_lat [16] = '{6, 6, 6, 6, 0, 0, 0, 0, 0, 6, 0, 0, 6, 6, 0, 0};

    initial begin
        logic [31:0] x;
        logic [7:0]  expd;
        int          lat;

        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        resetn = 1'b1;
        chk("reset", {in_ready, out_valid, out_data}, {1'b1, 1'b0, 8'h00});

        for (int i = 0; i < 16; i++) begin
            convert(dir_in[i], dir_out[i], dir_lat[i], (i == 1) ? 10 : (i % 2),
                    $sformatf("dir%0d", i));
        end

        // Abort mid-CALC: no result may surface afterwards.
        in_valid = 1'b1;
        in_data  = 32'h40000000;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b0;
        @(posedge clock); #1;
        resetn = 1'b1;
        chk("abort_state", {in_ready, out_valid, out_data}, {1'b1, 1'b0, 8'h00});
        repeat (8) @(posedge clock);
        #1;
        chk("abort_quiet", out_valid, 0);
        convert(32'h3F800000, 8'h00, F + 2, 1, "after_abort");

        for (int i = 0; i < 60; i++) begin
            x[31]    = 1'($urandom);
            x[22:0]  = 23'($urandom);
            if ($urandom_range(0, 9) < 8) x[30:23] = 8'($urandom_range(121, 132));
            else                          x[30:23] = 8'($urandom);
            expd = ref_log(x, lat);
            convert(x, expd, lat, $urandom_range(0, 2), $sformatf("rnd%0d_%h", i, x));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
